// File: rtl/ctrl_pkg.sv
// Shared opcode, ALU-function, next-PC and state definitions for the multi-cycle controller.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JRRT  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [5:0] ALU_NOP  = 6'b000000;
  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;
  localparam logic [5:0] ALU_AND  = 6'b100100;
  localparam logic [5:0] ALU_OR   = 6'b100101;
  localparam logic [5:0] ALU_SLT  = 6'b101010;

  localparam logic [1:0] CP_PC4    = 2'b00;
  localparam logic [1:0] CP_REG    = 2'b01;
  localparam logic [1:0] CP_JUMP   = 2'b10;
  localparam logic [1:0] CP_BRANCH = 2'b11;

  typedef enum logic [2:0] {
    ST_HALT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_PCUP   = 3'd6
  } state_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: datapath controls plus the class flags the sequencer needs.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opecode,
  input  logic [5:0] funct,
  input  logic       zflag,
  output logic [5:0] alu_func,
  output logic       reorim,
  output logic [1:0] cp_type,
  output logic       jrorrt,
  output logic       enbranch,
  output logic       is_mem,
  output logic       is_store,
  output logic       writes_reg,
  output logic       writes_lr
);

  always_comb begin
    alu_func   = ALU_NOP;
    reorim     = 1'b0;
    cp_type    = CP_PC4;
    writes_reg = 1'b0;
    case (opecode)
      OP_RTYPE: begin
        alu_func   = funct;
        writes_reg = (funct != FN_JR);
        if (funct == FN_JR) cp_type = CP_REG;
      end
      OP_ADDI, OP_LW: begin
        alu_func   = ALU_ADD;
        reorim     = 1'b1;
        writes_reg = 1'b1;
      end
      OP_SW: begin
        alu_func = ALU_ADD;
        reorim   = 1'b1;
      end
      OP_ANDI: begin
        alu_func   = ALU_AND;
        reorim     = 1'b1;
        writes_reg = 1'b1;
      end
      OP_ORI: begin
        alu_func   = ALU_OR;
        reorim     = 1'b1;
        writes_reg = 1'b1;
      end
      OP_SLTI: begin
        alu_func   = ALU_SLT;
        reorim     = 1'b1;
        writes_reg = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        alu_func = ALU_SUB;
        cp_type  = CP_BRANCH;
      end
      OP_J, OP_JAL: cp_type = CP_JUMP;
      OP_HALT:      cp_type = CP_REG;
      default: ;
    endcase
  end

  // bne is beq with opecode[0] set, so one xor covers both branch senses
  assign enbranch  = zflag ^ opecode[0];
  assign jrorrt    = (opecode == OP_JRRT);
  assign is_mem    = (opecode == OP_LW) || (opecode == OP_SW);
  assign is_store  = (opecode == OP_SW);
  assign writes_lr = (opecode == OP_JAL);

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle instruction sequencer with registered write/memory strobes.
// Optional retired-instruction counter enabled by MC_CONTROLLER_RETIRE_CNT_EN.
//
// state  | meaning
// HALT   | idle, waits for opecode 000000 to start
// FETCH  | instruction fetch
// DECODE | decode; opecode 111111 halts here
// EXEC   | ALU, held EXEC_CYCLES cycles by down-counter
// MEM    | lw/sw access, waits for mem_ready
// WB     | register / link-register write
// PCUP   | PC update
module mc_controller
  import ctrl_pkg::*;
#(
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 4,
  parameter int ICNT_W      = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [5:0]        opecode,
  input  logic [5:0]        funct,
  input  logic              zflag,
  input  logic              mem_ready,
  output logic [5:0]        alu_func,
  output logic              reorim,
  output logic [1:0]        cp_type,
  output logic              jrorrt,
  output logic              enbranch,
  output logic              write_reg,
  output logic              write_lr,
  output logic              write_pc,
  output logic              mem_req,
  output logic              mem_we,
  output logic              busy
`ifdef MC_CONTROLLER_RETIRE_CNT_EN
  ,
  output logic [ICNT_W-1:0] retired
`endif
);

  if ((2 ** CNT_W) < EXEC_CYCLES || EXEC_CYCLES < 1 || ICNT_W < 1) begin : g_param_err
    $error("mc_controller: illegal EXEC_CYCLES/CNT_W/ICNT_W combination");
  end

  localparam logic [CNT_W-1:0] EXEC_LOAD = CNT_W'(EXEC_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             is_mem, is_store, writes_reg, writes_lr;

  ctrl_decode u_decode (
    .opecode    (opecode),
    .funct      (funct),
    .zflag      (zflag),
    .alu_func   (alu_func),
    .reorim     (reorim),
    .cp_type    (cp_type),
    .jrorrt     (jrorrt),
    .enbranch   (enbranch),
    .is_mem     (is_mem),
    .is_store   (is_store),
    .writes_reg (writes_reg),
    .writes_lr  (writes_lr)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HALT:   if (opecode == OP_RTYPE) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = (opecode == OP_HALT) ? ST_HALT : ST_EXEC;
      ST_EXEC:   if (cnt_q == '0) state_d = is_mem ? ST_MEM : ST_WB;
      ST_MEM:    if (mem_ready) state_d = ST_WB;
      ST_WB:     state_d = ST_PCUP;
      ST_PCUP:   state_d = ST_FETCH;
      default:   state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_HALT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE)
        cnt_q <= EXEC_LOAD;
      else if (state_q == ST_EXEC && cnt_q != '0)
        cnt_q <= cnt_q - 1'b1;
    end
  end

  // Strobes are registered from the next state so each is a clean flop output
  // that is high exactly while the FSM sits in the corresponding state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      write_reg <= 1'b0;
      write_lr  <= 1'b0;
      write_pc  <= 1'b0;
    end else begin
      mem_req   <= (state_d == ST_MEM);
      mem_we    <= (state_d == ST_MEM) && is_store;
      write_reg <= (state_d == ST_WB) && writes_reg;
      write_lr  <= (state_d == ST_WB) && writes_lr;
      write_pc  <= (state_d == ST_PCUP);
    end
  end

  assign busy = (state_q != ST_HALT);

`ifdef MC_CONTROLLER_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      retired <= '0;
    else if (state_q == ST_PCUP)
      retired <= retired + 1'b1;
  end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Randomized self-checking bench for mc_controller against a per-instruction cycle-sequence model.
module tb_mc_controller;

  localparam int EXEC_CYC = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [5:0]  opecode = 6'h3f;
  logic [5:0]  funct = 6'h00;
  logic        zflag = 1'b0;
  logic        mem_ready = 1'b0;
  logic [5:0]  alu_func;
  logic        reorim, jrorrt, enbranch;
  logic [1:0]  cp_type;
  logic        write_reg, write_lr, write_pc, mem_req, mem_we, busy;
`ifdef MC_CONTROLLER_RETIRE_CNT_EN
  logic [31:0] retired;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned exp_ret = 0;

  mc_controller #(.EXEC_CYCLES(EXEC_CYC), .CNT_W(4), .ICNT_W(32)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .opecode   (opecode),
    .funct     (funct),
    .zflag     (zflag),
    .mem_ready (mem_ready),
    .alu_func  (alu_func),
    .reorim    (reorim),
    .cp_type   (cp_type),
    .jrorrt    (jrorrt),
    .enbranch  (enbranch),
    .write_reg (write_reg),
    .write_lr  (write_lr),
    .write_pc  (write_pc),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .busy      (busy)
`ifdef MC_CONTROLLER_RETIRE_CNT_EN
    ,
    .retired   (retired)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {busy, mem_req, mem_we, write_reg, write_lr, write_pc}
  function automatic logic [5:0] strobes();
    return {busy, mem_req, mem_we, write_reg, write_lr, write_pc};
  endfunction

  function automatic logic [5:0] ref_alu(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00:               return fn;
      6'h08, 6'h23, 6'h2b: return 6'b100000;
      6'h0c:               return 6'b100100;
      6'h0d:               return 6'b100101;
      6'h0a:               return 6'b101010;
      6'h04, 6'h05:        return 6'b100010;
      default:             return 6'b000000;
    endcase
  endfunction

  function automatic logic ref_imm(input logic [5:0] op);
    return op inside {6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h23, 6'h2b};
  endfunction

  function automatic logic [1:0] ref_cp(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h3f || (op == 6'h00 && fn == 6'h08)) return 2'b01;
    if (op inside {6'h02, 6'h03}) return 2'b10;
    if (op inside {6'h04, 6'h05}) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic ref_wreg(input logic [5:0] op, input logic [5:0] fn);
    return (op == 6'h00 && fn != 6'h08) || (op inside {6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h23});
  endfunction

  task automatic chk_retired(input string tag);
`ifdef MC_CONTROLLER_RETIRE_CNT_EN
    chk(tag, retired, exp_ret);
`else
    if (tag.len() == 0) n_cmp = n_cmp;
`endif
  endtask

  // Called with the DUT just entered FETCH; runs one instruction and returns in the next FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic zf, input int k);
    logic [5:0] q[$];
    bit         mem_op;
    int         m0;
    opecode = op;
    funct   = fn;
    zflag   = zf;
    #1;
    chk("alu_func", alu_func, ref_alu(op, fn));
    chk("reorim", reorim, ref_imm(op));
    chk("cp_type", cp_type, ref_cp(op, fn));
    chk("jrorrt", jrorrt, op == 6'h01);
    chk("enbranch", enbranch, zf ^ op[0]);
    mem_op = (op == 6'h23 || op == 6'h2b);
    q.push_back(6'b100000);
    q.push_back(6'b100000);
    for (int i = 0; i < EXEC_CYC; i++) q.push_back(6'b100000);
    m0 = q.size();
    if (mem_op)
      for (int i = 0; i <= k; i++) q.push_back({2'b11, op == 6'h2b, 3'b000});
    q.push_back({3'b100, ref_wreg(op, fn), op == 6'h03, 1'b0});
    q.push_back(6'b100001);
    for (int i = 0; i < q.size(); i++) begin
      chk($sformatf("seq op=%02h cyc%0d", op, i), strobes(), q[i]);
      if (mem_op && i >= m0 && i <= m0 + k) mem_ready = (i == m0 + k);
      else mem_ready = 1'($urandom);
      tick();
    end
    mem_ready = 1'b0;
    exp_ret++;
    chk("next_fetch", strobes(), 6'b100000);
    chk_retired("retired");
  endtask

  task automatic run_halt();
    opecode = 6'h3f;
    funct   = 6'($urandom);
    #1;
    chk("halt cp_type", cp_type, 2'b01);
    chk("halt fetch", strobes(), 6'b100000);
    tick();
    chk("halt decode", strobes(), 6'b100000);
    mem_ready = 1'($urandom);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("halted", strobes(), 6'b000000);
      mem_ready = 1'($urandom);
      tick();
    end
    chk_retired("retired halt");
    opecode = 6'h00;
    tick();
    chk("restart fetch", strobes(), 6'b100000);
  endtask

  logic [5:0] ops [13] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08,
                           6'h0a, 6'h0c, 6'h0d, 6'h23, 6'h2b, 6'h10};

  initial begin
    logic [5:0] op, fn;
    #12;
    chk("reset strobes", strobes(), 6'b000000);
    chk_retired("reset retired");
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle halt", strobes(), 6'b000000);
    end
    opecode = 6'h00;
    tick();
    chk("start fetch", strobes(), 6'b100000);

    run_instr(6'h08, 6'h15, 1'b0, 0);   // addi
    run_instr(6'h23, 6'h00, 1'b0, 3);   // lw, 3 wait cycles
    run_instr(6'h2b, 6'h00, 1'b1, 1);   // sw
    run_instr(6'h04, 6'h00, 1'b1, 0);   // beq, zflag=1
    run_instr(6'h05, 6'h00, 1'b1, 0);   // bne, zflag=1
    run_instr(6'h00, 6'h20, 1'b0, 0);   // add
    run_instr(6'h03, 6'h00, 1'b0, 0);   // jal
    run_instr(6'h00, 6'h08, 1'b0, 0);   // jr
    run_instr(6'h2b, 6'h00, 1'b0, 0);   // sw, immediate ready
    run_halt();

    for (int n = 0; n < 45; n++) begin
      if ($urandom_range(9) == 0) begin
        run_halt();
      end else begin
        op = ops[$urandom_range(12)];
        fn = ($urandom_range(3) == 0) ? 6'h08 : 6'($urandom);
        run_instr(op, fn, 1'($urandom), int'($urandom_range(4)));
      end
    end

    // reset in the middle of a load's MEM phase
    opecode = 6'h23;
    mem_ready = 1'b0;
    for (int i = 0; i < 2 + EXEC_CYC; i++) tick();
    chk("mem before rst", strobes(), 6'b110000);
    #2 rstn = 1'b0;
    #1;
    exp_ret = 0;
    chk("mid-mem reset", strobes(), 6'b000000);
    chk_retired("retired after rst");
    opecode = 6'h00;
    @(negedge clk);
    rstn = 1'b1;
    tick();
    chk("fetch after rst", strobes(), 6'b100000);
    run_instr(6'h0d, 6'h00, 1'b0, 0);   // ori
    run_halt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Parametrised multi-cycle sequencer for the single-issue core.
- Decodes `opecode`/`funct` into ALU/operand/PC-source controls.
- Sequences each instruction through FETCH, DECODE, EXEC, optional MEM and WB phases, with a configurable EXEC latency and a memory-ready handshake.
- Drives the register-file, link-register and PC write strobes.

Parameters:
- EXEC_CYCLES, 1, cycles spent in EXEC (1..16) to cover multi-cycle ALU ops.
- CNT_W, 4, width of the EXEC down-counter; must satisfy 2**CNT_W >= EXEC_CYCLES.
- ICNT_W, 32, width of the retired-instruction counter; used only with the optional feature.

Ports:
- clk  in  1  core clock
- rstn  in  1  reset, asynchronous, active-low
- opecode  in  6  instruction opcode, stable from FETCH until PCUP
- funct  in  6  R-type function field
- zflag  in  1  ALU zero flag
- mem_ready  in  1  data memory done; sampled only in MEM
- alu_func  out  6  ALU function select
- reorim  out  1  1 selects the immediate as the second operand
- cp_type  out  2  next-PC source: 00 pc+4, 01 register/halt, 10 jump, 11 branch
- jrorrt  out  1  high when opecode==6'b000001
- enbranch  out  1  zflag ^ opecode[0]
- write_reg  out  1  register-file write strobe
- write_lr  out  1  link-register write strobe
- write_pc  out  1  PC write strobe
- mem_req  out  1  data memory request
- mem_we  out  1  data memory write enable; valid while mem_req is high
- busy  out  1  high in every state except HALT
- retired  out  ICNT_W  retired-instruction count; present only with the optional feature

Behaviour:
- Decode (combinational from opecode/funct):
  - alu_func:
    - opecode 0 -> funct
    - addi/lw/sw (001000/100011/101011) -> 100000
    - andi 001100 -> 100100
    - ori 001101 -> 100101
    - slti 001010 -> 101010
    - beq/bne (000100/000101) -> 100010
    - otherwise -> 000000
  - reorim = 1 for addi, andi, ori, slti, lw, sw.
  - cp_type:
    - 01 for opecode 111111, or opecode 0 with funct 001000 (jr)
    - 10 for j/jal (000010/000011)
    - 11 for beq/bne
    - otherwise 00
- State encoding: 3 bits. HALT=0, FETCH, DECODE, EXEC, MEM, WB, PCUP.
- Reset (async, rstn low): state HALT, EXEC counter 0, all strobes 0, busy 0, retired 0. Reset mid-instruction abandons it with no strobe glitch.
- Transitions:
  - HALT -> FETCH when opecode==000000 is sampled; otherwise stay in HALT.
  - FETCH -> DECODE.
  - DECODE:
    - opecode==111111 -> HALT.
    - Otherwise -> EXEC, loading the counter with EXEC_CYCLES-1.
  - EXEC:
    - Counter != 0: decrement and stay.
    - Counter == 0, lw/sw -> MEM.
    - Counter == 0, anything else -> WB.
  - MEM: stay until mem_ready==1 at a clock edge, then -> WB. mem_ready outside MEM is ignored. There is no timeout.
  - WB -> PCUP.
  - PCUP -> FETCH.
- Moore outputs, all from the state register (no combinational path from inputs):
  - mem_req = 1 in MEM; mem_we = 1 in MEM when opecode is sw.
  - write_reg = 1 in WB for R-type except jr, and for addi/andi/ori/slti/lw.
  - write_reg = 0 in WB for beq, bne, sw, j, jr.
  - write_lr = 1 in WB for jal (000011) only.
  - write_pc = 1 in PCUP only.
- Latency: ALU op with EXEC_CYCLES=1 takes 5 cycles, FETCH to PCUP inclusive. Load/store takes 5 + (MEM cycles).
- Every strobe is high for exactly one cycle per instruction.
- Halt from DECODE produces no write_pc.

Optional Feature:
- Macro: MC_CONTROLLER_RETIRE_CNT_EN.
- Defined:
  - `retired` port exists.
  - Counter increments by 1 on each PCUP cycle and wraps modulo 2**ICNT_W.
  - Cleared only by reset; holds its value across HALT.
- Undefined: port and counter are absent.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_HALT, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_JAL, …)
  - ALU function codes
  - cp_type codes
  - state enum
- Sub-module ctrl_decode: purely combinational decode of alu_func/reorim/cp_type/jrorrt/enbranch plus the is_mem, is_store, writes_reg, writes_lr flags.
- mc_controller keeps the FSM, the counter and the optional retire counter.

Test Plan:
- Reset released with opecode=0x3F: stays HALT, busy=0, all strobes 0. Then opecode=0x00: FETCH next cycle, busy=1.
- addi (001000), EXEC_CYCLES=1: alu_func=100000, reorim=1; write_reg pulses in cycle 4 after FETCH; write_pc pulses in cycle 5; retired increments by 1.
- lw with mem_ready held low 3 cycles in MEM: mem_req high for 4 cycles, mem_we=0; then WB write_reg=1, then write_pc.
- sw: mem_we=1 during MEM, write_reg stays 0. beq with zflag=1: enbranch=1, cp_type=11, no write_reg. bne with zflag=1: enbranch=0.
- EXEC_CYCLES=4 build, R-type add: exactly 4 EXEC cycles. jal: write_lr=1, write_reg=0. jr (funct 001000): cp_type=01.
- rstn asserted during MEM: immediate HALT, mem_req=0, retired=0. opecode 0x3F at DECODE: HALT with no write_pc.
